// File: rtl/hwpe_ctrl_seq_mult_issue.sv
// rtl/hwpe_ctrl_seq_mult_issue.sv - issue/collect stage in front of the sequential multiplier
module hwpe_ctrl_seq_mult_issue #(
   parameter int unsigned AW      = 8,
   parameter int unsigned BW      = 8,
   parameter int unsigned TIMEOUT = AW + 4
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             clear_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [AW-1:0]    in_a_i,
   input  logic [BW-1:0]    in_b_i,
   output logic             mult_start_o,
   output logic [AW-1:0]    mult_a_o,
   output logic [BW-1:0]    mult_b_o,
   input  logic             mult_valid_i,
   input  logic [AW+BW-1:0] mult_prod_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [AW+BW-1:0] out_prod_o,
   output logic             err_o
);

   // Counter must hold the value TIMEOUT itself.
   localparam int unsigned     CW        = $clog2(TIMEOUT + 1);
   localparam logic [CW-1:0]   CNT_LIMIT = CW'(TIMEOUT);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_START = 2'd1,
      S_BUSY  = 2'd2,
      S_DONE  = 2'd3
   } state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      cnt_q, cnt_d;
   logic [AW-1:0]      a_q, a_d;
   logic [BW-1:0]      b_q, b_d;
   logic [AW+BW-1:0]   prod_q, prod_d;
   logic               out_valid_q, out_valid_d;
   logic               err_q, err_d;
   logic               ready;
   logic               start;

   // Next-state and handshake decode; clear_i overrides every state.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      a_d         = a_q;
      b_d         = b_q;
      prod_d      = prod_q;
      out_valid_d = out_valid_q;
      err_d       = err_q;
      ready       = 1'b0;
      start       = 1'b0;

      if (clear_i) begin
         state_d     = S_IDLE;
         cnt_d       = '0;
         a_d         = '0;
         b_d         = '0;
         prod_d      = '0;
         out_valid_d = 1'b0;
         err_d       = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               ready = 1'b1;
               if (in_valid_i) begin
                  a_d     = in_a_i;
                  b_d     = in_b_i;
                  state_d = S_START;
               end
            end
            S_START: begin
               // Any mult_valid_i seen here belongs to the previous operation.
               start   = 1'b1;
               cnt_d   = '0;
               state_d = S_BUSY;
            end
            S_BUSY: begin
               cnt_d = cnt_q + 1'b1;
               // A product arriving on the timeout cycle still wins.
               if (mult_valid_i) begin
                  prod_d      = mult_prod_i;
                  out_valid_d = 1'b1;
                  state_d     = S_DONE;
               end else if (cnt_d == CNT_LIMIT) begin
                  err_d   = 1'b1;
                  state_d = S_IDLE;
               end
            end
            S_DONE: begin
               ready = out_ready_i;
               if (out_ready_i) begin
                  out_valid_d = 1'b0;
                  // Taking the next pair here avoids an IDLE bubble.
                  if (in_valid_i) begin
                     a_d     = in_a_i;
                     b_d     = in_b_i;
                     state_d = S_START;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // State and datapath registers.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= S_IDLE;
         cnt_q       <= '0;
         a_q         <= '0;
         b_q         <= '0;
         prod_q      <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         a_q         <= a_d;
         b_q         <= b_d;
         prod_q      <= prod_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

   // Ready is masked during reset so every output reads 0 while rst_ni is low.
   assign in_ready_o   = ready & rst_ni;
   assign mult_start_o = start;
   assign mult_a_o     = a_q;
   assign mult_b_o     = b_q;
   assign out_valid_o  = out_valid_q;
   assign out_prod_o   = prod_q;
   assign err_o        = err_q;

endmodule

// File: tb/tb_hwpe_ctrl_seq_mult_issue.sv
// tb/tb_hwpe_ctrl_seq_mult_issue.sv - randomized and directed bench with a transaction-level model
module tb_hwpe_ctrl_seq_mult_issue;

   localparam int AW = 8;
   localparam int BW = 8;
   localparam int TO = AW + 4;
   localparam int PW = AW + BW;

   logic          clk_i = 1'b0;
   logic          rst_ni = 1'b0;
   logic          clear_i = 1'b0;
   logic          in_valid_i = 1'b0;
   logic          in_ready_o;
   logic [AW-1:0] in_a_i = '0;
   logic [BW-1:0] in_b_i = '0;
   logic          mult_start_o;
   logic [AW-1:0] mult_a_o;
   logic [BW-1:0] mult_b_o;
   logic          mult_valid_i = 1'b0;
   logic [PW-1:0] mult_prod_i = '0;
   logic          out_valid_o;
   logic          out_ready_i = 1'b1;
   logic [PW-1:0] out_prod_o;
   logic          err_o;

   hwpe_ctrl_seq_mult_issue #(.AW(AW), .BW(BW), .TIMEOUT(TO)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .clear_i(clear_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_a_i(in_a_i), .in_b_i(in_b_i),
      .mult_start_o(mult_start_o), .mult_a_o(mult_a_o), .mult_b_o(mult_b_o),
      .mult_valid_i(mult_valid_i), .mult_prod_i(mult_prod_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i), .out_prod_o(out_prod_o),
      .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic fail_bound(input string name);
      total++;
      bad++;
      $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
   endtask

   // Transaction-level model: an operation is queued on acceptance, waits one cycle
   // for its start pulse, then waits for the product or gives up after TO cycles.
   bit            m_pending = 0;
   bit            m_waiting = 0;
   bit            m_have    = 0;
   bit            m_err     = 0;
   int            m_cnt     = 0;
   logic [PW-1:0] m_result  = '0;
   logic [AW-1:0] m_a       = '0;
   logic [BW-1:0] m_b       = '0;
   logic [PW-1:0] m_q[$];

   function automatic bit exp_ready();
      return rst_ni && !clear_i &&
             ((!m_pending && !m_waiting && !m_have) || (m_have && out_ready_i));
   endfunction

   initial begin
      bit acc, hs;
      forever begin
         @(posedge clk_i or negedge rst_ni);
         if (!rst_ni || clear_i) begin
            m_pending = 0; m_waiting = 0; m_have = 0; m_err = 0; m_cnt = 0;
            m_result = '0; m_a = '0; m_b = '0;
            m_q.delete();
         end else begin
            acc = in_valid_i && exp_ready();
            hs  = m_have && out_ready_i;
            if (m_waiting) begin
               m_cnt++;
               if (mult_valid_i) begin
                  m_result  = (m_q.size() > 0) ? m_q.pop_front() : '1;
                  m_have    = 1;
                  m_waiting = 0;
               end else if (m_cnt == TO) begin
                  m_err     = 1;
                  m_waiting = 0;
                  if (m_q.size() > 0) void'(m_q.pop_front());
               end
            end else if (m_pending) begin
               m_pending = 0;
               m_waiting = 1;
               m_cnt     = 0;
            end
            if (hs) m_have = 0;
            if (acc) begin
               m_a = in_a_i;
               m_b = in_b_i;
               m_q.push_back(PW'(in_a_i) * PW'(in_b_i));
               m_pending = 1;
            end
         end
      end
   end

   // Multiplier stub: answers a*b after sdel BUSY cycles (0 = never), optionally
   // raising a stale valid with garbage during the START cycle.
   int stub_delay_cfg = -1;
   int stub_stale_cfg = -1;
   initial begin
      bit            armed = 0;
      int            scnt = 0;
      int            sdel = 0;
      logic [AW-1:0] sa = '0;
      logic [BW-1:0] sb = '0;
      forever begin
         @(negedge clk_i);
         #1;
         mult_valid_i = 1'b0;
         mult_prod_i  = PW'($urandom);
         if (mult_start_o) begin
            armed = 1;
            scnt  = 0;
            sa    = mult_a_o;
            sb    = mult_b_o;
            if (stub_delay_cfg >= 0) sdel = stub_delay_cfg;
            else sdel = ($urandom_range(0, 19) == 0) ? 0 : int'($urandom_range(1, TO));
            if ((stub_stale_cfg >= 0) ? (stub_stale_cfg != 0) : ($urandom_range(0, 1) == 1))
               mult_valid_i = 1'b1;
         end else if (armed) begin
            scnt++;
            if (sdel != 0 && scnt == sdel) begin
               mult_valid_i = 1'b1;
               mult_prod_i  = PW'(sa) * PW'(sb);
               armed = 0;
            end
         end
      end
   end

   // Event monitor used by the directed tests.
   int            acc_cnt = 0;
   int            last_acc = 0;
   int            starts = 0;
   int            ov_rise = 0;
   int            err_rise = 0;
   int            acc_q[$];
   logic [PW-1:0] res_q[$];
   initial begin
      bit prev_ov = 0;
      bit prev_err = 0;
      forever begin
         @(negedge clk_i);
         #2;
         if (rst_ni && in_valid_i && in_ready_o) begin
            acc_cnt++;
            last_acc = cyc;
            acc_q.push_back(cyc);
         end
         if (out_valid_o && out_ready_i && !clear_i) res_q.push_back(out_prod_o);
         if (mult_start_o) starts++;
         if (out_valid_o && !prev_ov) ov_rise = cyc;
         if (err_o && !prev_err) err_rise = cyc;
         prev_ov  = out_valid_o;
         prev_err = err_o;
      end
   end

   // Cycle-by-cycle comparison of every output against the model.
   initial begin
      forever begin
         @(negedge clk_i);
         #3;
         chk("in_ready",   32'(in_ready_o),   32'(exp_ready()));
         chk("mult_start", 32'(mult_start_o), 32'(rst_ni && !clear_i && m_pending));
         chk("mult_a",     32'(mult_a_o),     32'(m_a));
         chk("mult_b",     32'(mult_b_o),     32'(m_b));
         chk("out_valid",  32'(out_valid_o),  32'(m_have));
         chk("out_prod",   32'(out_prod_o),   32'(m_result));
         chk("err",        32'(err_o),        32'(m_err));
      end
   end

   task automatic push(input logic [AW-1:0] a, input logic [BW-1:0] b);
      bit ok = 0;
      @(negedge clk_i);
      in_valid_i = 1'b1;
      in_a_i = a;
      in_b_i = b;
      for (int n = 0; n < 200; n++) begin
         #1;
         if (in_ready_o) begin
            ok = 1;
            break;
         end
         @(negedge clk_i);
      end
      if (!ok) fail_bound("accept");
   endtask

   task automatic idle_in();
      @(negedge clk_i);
      in_valid_i = 1'b0;
   endtask

   task automatic wait_res(input string name, input logic [PW-1:0] exp);
      bit ok = 0;
      for (int n = 0; n < 100; n++) begin
         if (res_q.size() > 0) begin
            ok = 1;
            break;
         end
         @(negedge clk_i);
         #4;
      end
      if (ok) chk(name, 32'(res_q.pop_front()), 32'(exp));
      else fail_bound(name);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
      $fatal(1);
   end

   initial begin
      int a0;
      int n0;
      bit ok;

      // Reset values
      repeat (3) @(negedge clk_i);
      #1;
      chk("rst_ready", 32'(in_ready_o), 0);
      chk("rst_prod",  32'(out_prod_o), 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      @(negedge clk_i);
      #1;
      chk("idle_ready", 32'(in_ready_o), 1);

      // Single operation, slowest compliant multiplier
      stub_delay_cfg = AW + 1;
      stub_stale_cfg = 0;
      starts = 0;
      push(3, 5);
      idle_in();
      a0 = last_acc;
      wait_res("single_prod", 15);
      chk("single_latency", 32'(ov_rise - a0), AW + 3);
      chk("single_starts", 32'(starts), 1);

      // Back-to-back with out_ready_i high
      acc_q.delete();
      push(255, 255);
      push(0, 77);
      push(128, 2);
      idle_in();
      wait_res("b2b_0", 65025);
      wait_res("b2b_1", 0);
      wait_res("b2b_2", 256);
      if (acc_q.size() == 3) begin
         chk("b2b_gap1", 32'(acc_q[1] - acc_q[0]), AW + 3);
         chk("b2b_gap2", 32'(acc_q[2] - acc_q[1]), AW + 3);
      end else begin
         chk("b2b_accepts", 32'(acc_q.size()), 3);
      end

      // Backpressure: result held, no acceptance until out_ready_i rises
      @(negedge clk_i);
      out_ready_i = 1'b0;
      push(200, 3);
      @(negedge clk_i);
      in_a_i = 1;
      in_b_i = 1;
      ok = 0;
      for (int n = 0; n < 50; n++) begin
         #1;
         if (out_valid_o) begin
            ok = 1;
            break;
         end
         @(negedge clk_i);
      end
      if (!ok) fail_bound("bp_valid");
      n0 = acc_cnt;
      repeat (20) begin
         @(negedge clk_i);
         #1;
         chk("bp_hold_prod",  32'(out_prod_o), 600);
         chk("bp_hold_ready", 32'(in_ready_o), 0);
      end
      @(negedge clk_i);
      out_ready_i = 1'b1;
      @(negedge clk_i);
      in_valid_i = 1'b0;
      wait_res("bp_prod", 600);
      wait_res("bp_next", 1);
      chk("bp_single_accept", 32'(acc_cnt - n0), 1);

      // Timeout with a silent multiplier, then soft clear
      stub_delay_cfg = 0;
      push(1, 2);
      idle_in();
      a0 = last_acc;
      ok = 0;
      for (int n = 0; n < 60; n++) begin
         @(negedge clk_i);
         #3;
         if (err_o) begin
            ok = 1;
            break;
         end
      end
      if (!ok) fail_bound("to_err");
      chk("to_cycles", 32'(err_rise - a0), TO + 2);
      chk("to_no_result", 32'(res_q.size()), 0);
      chk("to_idle_ready", 32'(in_ready_o), 1);
      @(negedge clk_i);
      clear_i = 1'b1;
      @(negedge clk_i);
      clear_i = 1'b0;
      #1;
      chk("clr_err", 32'(err_o), 0);

      // Product on the timeout cycle is still captured
      stub_delay_cfg = TO;
      push(4, 4);
      idle_in();
      wait_res("to_edge_prod", 16);
      chk("to_edge_err", 32'(err_o), 0);

      // Stale valid during START is ignored
      stub_delay_cfg = 3;
      stub_stale_cfg = 1;
      push(10, 11);
      idle_in();
      wait_res("stale_prod", 110);
      stub_stale_cfg = 0;

      // Reset in BUSY cycle 3, then a fresh operation
      stub_delay_cfg = TO;
      push(50, 50);
      idle_in();
      repeat (3) @(negedge clk_i);
      rst_ni = 1'b0;
      #1;
      chk("rstmid_valid", 32'(out_valid_o), 0);
      chk("rstmid_a",     32'(mult_a_o), 0);
      chk("rstmid_prod",  32'(out_prod_o), 0);
      @(negedge clk_i);
      rst_ni = 1'b1;
      stub_delay_cfg = 2;
      push(7, 9);
      idle_in();
      wait_res("rstmid_next", 63);

      // Clear in BUSY cycle 3, then a fresh operation
      stub_delay_cfg = TO;
      push(60, 60);
      idle_in();
      repeat (3) @(negedge clk_i);
      clear_i = 1'b1;
      #1;
      chk("clrmid_start", 32'(mult_start_o), 0);
      chk("clrmid_ready", 32'(in_ready_o), 0);
      @(negedge clk_i);
      clear_i = 1'b0;
      #1;
      chk("clrmid_valid", 32'(out_valid_o), 0);
      chk("clrmid_b",     32'(mult_b_o), 0);
      stub_delay_cfg = 2;
      push(7, 9);
      idle_in();
      wait_res("clrmid_next", 63);
      chk("clrmid_no_extra", 32'(res_q.size()), 0);

      // Randomized traffic against the model
      stub_delay_cfg = -1;
      stub_stale_cfg = -1;
      repeat (3000) begin
         @(negedge clk_i);
         in_valid_i  = ($urandom_range(0, 9) < 7);
         in_a_i      = AW'($urandom);
         in_b_i      = BW'($urandom);
         out_ready_i = ($urandom_range(0, 3) != 0);
         clear_i     = ($urandom_range(0, 99) == 0);
         rst_ni      = ($urandom_range(0, 299) != 0);
      end
      @(negedge clk_i);
      in_valid_i  = 1'b0;
      out_ready_i = 1'b1;
      clear_i     = 1'b0;
      rst_ni      = 1'b1;
      repeat (40) @(negedge clk_i);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
